// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the N-way cache controller: FSM states, one-hot
// encoder and tree pseudo-LRU functions (sized for up to 16 ways).
package cache_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StFill} state_e;

   // Lowest set bit wins when several are set.
   function automatic logic [3:0] onehot2idx(input logic [15:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
   // A bit of 0 sends the victim search to the lower half.
   function automatic logic [3:0] plru_victim(input logic [14:0] bits, input int unsigned levels);
      logic [4:0] node;
      logic [3:0] way;
      node = '0;
      way  = '0;
      for (int unsigned l = 0; l < 4; l++) begin
         if (l < levels) begin
            way  = {way[2:0], bits[node[3:0]]};
            node = {node[3:0], 1'b0} + 5'd1 + {4'd0, bits[node[3:0]]};
         end
      end
      return way;
   endfunction

   function automatic logic [14:0] plru_update(input logic [14:0] bits, input logic [3:0] way,
                                               input int unsigned levels);
      logic [4:0]  node;
      logic [14:0] nbits;
      logic        b;
      node  = '0;
      nbits = bits;
      for (int unsigned l = 0; l < 4; l++) begin
         if (l < levels) begin
            b                  = way[2'(levels - 1 - l)];
            nbits[node[3:0]]   = ~b;
            node               = {node[3:0], 1'b0} + 5'd1 + {4'd0, b};
         end
      end
      return nbits;
   endfunction

endpackage

// File: rtl/nway_cache_control_if.sv
// CPU / array datapath / physical memory signals around the cache controller.
interface nway_cache_control_if #(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned S_INDEX  = 3,
   parameter int unsigned CNT_W    = 32
);
   localparam int unsigned WayW = $clog2(NUM_WAYS);

   logic                mem_read;
   logic                mem_write;
   logic                mem_resp;
   logic [S_INDEX-1:0]  set_idx;
   logic [NUM_WAYS-1:0] hit_vec;
   logic [NUM_WAYS-1:0] valid_vec;
   logic [NUM_WAYS-1:0] dirty_vec;
   logic [WayW-1:0]     way_sel;
   logic [NUM_WAYS-1:0] load_data;
   logic [NUM_WAYS-1:0] load_tag;
   logic [NUM_WAYS-1:0] load_valid;
   logic [NUM_WAYS-1:0] load_dirty;
   logic                data_in_sel;
   logic                dirty_in;
   logic                pmem_addr_sel;
   logic                pmem_read;
   logic                pmem_write;
   logic                pmem_resp;
   logic [CNT_W-1:0]    hit_count;
   logic [CNT_W-1:0]    miss_count;

   // master: CPU, arrays and memory; slave: the controller
   modport master (
      output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
      input  mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, data_in_sel,
             dirty_in, pmem_addr_sel, pmem_read, pmem_write, hit_count, miss_count
   );

   modport slave (
      input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
      output mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, data_in_sel,
             dirty_in, pmem_addr_sel, pmem_read, pmem_write, hit_count, miss_count
   );
endinterface

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state with a synchronous clear, one update port and a
// combinational victim lookup.
module plru_array
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned S_INDEX  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_upd_en,
   input  logic [S_INDEX-1:0]          i_upd_set,
   input  logic [$clog2(NUM_WAYS)-1:0] i_upd_way,
   input  logic [S_INDEX-1:0]          i_rd_set,
   output logic [$clog2(NUM_WAYS)-1:0] o_victim
);
   localparam int unsigned NumSets = 1 << S_INDEX;
   localparam int unsigned TreeW   = NUM_WAYS - 1;
   localparam int unsigned WayW    = $clog2(NUM_WAYS);
   localparam int unsigned Levels  = $clog2(NUM_WAYS);

   logic [TreeW-1:0] r_plru [NumSets];

   assign o_victim = WayW'(plru_victim(15'(r_plru[i_rd_set]), Levels));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NumSets; i++) r_plru[i] <= '0;
      end else if (i_upd_en) begin
         r_plru[i_upd_set] <= TreeW'(plru_update(15'(r_plru[i_upd_set]), 4'(i_upd_way), Levels));
      end
   end
endmodule

// File: rtl/nway_cache_control.sv
// N-way set-associative write-back cache controller with tree PLRU replacement,
// separate writeback/fill phases and saturating hit/miss counters.
module nway_cache_control
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned S_INDEX  = 3,
   parameter int unsigned CNT_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   nway_cache_control_if.slave bus
);
   localparam int unsigned WayW = $clog2(NUM_WAYS);

   state_e              r_state, w_state_d;
   logic [WayW-1:0]     r_victim, w_victim_d;
   logic                r_refill, w_refill_d;
   logic [CNT_W-1:0]    r_hit_count, r_miss_count;
   logic                w_hit_inc, w_miss_inc, w_plru_upd;
   logic                w_req;
   logic [NUM_WAYS-1:0] w_inv;
   logic [WayW-1:0]     w_hit_way, w_inv_way, w_plru_victim, w_miss_victim;

   assign w_req         = bus.mem_read | bus.mem_write;
   assign w_inv         = ~bus.valid_vec;
   assign w_hit_way     = WayW'(onehot2idx(16'(bus.hit_vec)));
   assign w_inv_way     = WayW'(onehot2idx(16'(w_inv)));
   assign w_miss_victim = (|w_inv) ? w_inv_way : w_plru_victim;
   assign bus.hit_count  = r_hit_count;
   assign bus.miss_count = r_miss_count;

   plru_array #(
      .NUM_WAYS(NUM_WAYS),
      .S_INDEX (S_INDEX)
   ) u_plru (
      .clk      (clk),
      .rst      (rst),
      .i_upd_en (w_plru_upd),
      .i_upd_set(bus.set_idx),
      .i_upd_way(w_hit_way),
      .i_rd_set (bus.set_idx),
      .o_victim (w_plru_victim)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_victim     <= '0;
         r_refill     <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_state  <= w_state_d;
         r_victim <= w_victim_d;
         r_refill <= w_refill_d;
         if (w_hit_inc && (r_hit_count != '1))   r_hit_count  <= r_hit_count + 1'b1;
         if (w_miss_inc && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
      end
   end

   always_comb begin
      w_state_d         = r_state;
      w_victim_d        = r_victim;
      w_refill_d        = r_refill;
      w_hit_inc         = 1'b0;
      w_miss_inc        = 1'b0;
      w_plru_upd        = 1'b0;
      bus.mem_resp      = 1'b0;
      bus.way_sel       = '0;
      bus.load_data     = '0;
      bus.load_tag      = '0;
      bus.load_valid    = '0;
      bus.load_dirty    = '0;
      bus.data_in_sel   = 1'b0;
      bus.dirty_in      = 1'b0;
      bus.pmem_addr_sel = 1'b0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_req) w_state_d = StCompare;
         end
         StCompare: begin
            if (!w_req) begin
               w_state_d  = StIdle;
               w_refill_d = 1'b0;
            end else if (|bus.hit_vec) begin
               bus.way_sel  = w_hit_way;
               bus.mem_resp = 1'b1;
               w_plru_upd   = 1'b1;
               w_hit_inc    = ~r_refill;  // the post-fill re-compare is not a hit
               w_refill_d   = 1'b0;
               w_state_d    = StIdle;
               if (bus.mem_write) begin
                  bus.load_data[w_hit_way]  = 1'b1;
                  bus.load_dirty[w_hit_way] = 1'b1;
                  bus.data_in_sel           = 1'b1;
                  bus.dirty_in              = 1'b1;
               end
            end else begin
               bus.way_sel = w_miss_victim;
               w_victim_d  = w_miss_victim;
               w_miss_inc  = 1'b1;
               w_state_d   = bus.dirty_vec[w_miss_victim] ? StWriteback : StFill;
            end
         end
         StWriteback: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = 1'b1;
            bus.way_sel       = r_victim;
            if (bus.pmem_resp) w_state_d = StFill;
         end
         StFill: begin
            bus.pmem_read = 1'b1;
            bus.way_sel   = r_victim;
            if (bus.pmem_resp) begin
               bus.load_data[r_victim]  = 1'b1;
               bus.load_tag[r_victim]   = 1'b1;
               bus.load_valid[r_victim] = 1'b1;
               bus.load_dirty[r_victim] = 1'b1;
               w_refill_d               = 1'b1;
               w_state_d                = StCompare;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end
endmodule

// File: tb/tb_nway_cache_control.sv
// Bench for nway_cache_control: a transaction-level cache/PLRU model predicts every
// cycle's outputs, which one negedge process compares against the DUT.
module tb_nway_cache_control;
   localparam int NW = 4;
   localparam int SI = 3;
   localparam int CW = 4;

   typedef struct {
      bit       resp;
      bit       chk_way;
      int       way;
      bit [3:0] ld_data, ld_tag, ld_valid, ld_dirty;
      bit       dsel, din, asel, prd, pwr;
      int       hc, mc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nway_cache_control_if #(.NUM_WAYS(NW), .S_INDEX(SI), .CNT_W(CW)) bus ();

   nway_cache_control #(.NUM_WAYS(NW), .S_INDEX(SI), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference model: tag store contents, PLRU tree bits per set, counters
   int   tag_m  [8][4];
   bit   val_m  [8][4];
   bit   dty_m  [8][4];
   bit   plru_m [8][3];
   int   hc, mc;
   int   n_checks, n_fail;
   exp_t exp_q[$];
   exp_t ce;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         chk("mem_resp", int'(bus.mem_resp), int'(ce.resp));
         if (ce.chk_way) chk("way_sel", int'(bus.way_sel), ce.way);
         chk("load_data", int'(bus.load_data), int'(ce.ld_data));
         chk("load_tag", int'(bus.load_tag), int'(ce.ld_tag));
         chk("load_valid", int'(bus.load_valid), int'(ce.ld_valid));
         chk("load_dirty", int'(bus.load_dirty), int'(ce.ld_dirty));
         chk("data_in_sel", int'(bus.data_in_sel), int'(ce.dsel));
         chk("dirty_in", int'(bus.dirty_in), int'(ce.din));
         chk("pmem_addr_sel", int'(bus.pmem_addr_sel), int'(ce.asel));
         chk("pmem_read", int'(bus.pmem_read), int'(ce.prd));
         chk("pmem_write", int'(bus.pmem_write), int'(ce.pwr));
         chk("hit_count", int'(bus.hit_count), ce.hc);
         chk("miss_count", int'(bus.miss_count), ce.mc);
      end
   end

   function automatic int sat(input int v);
      return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
   endfunction

   // Walk the tree by halving the way range; each visited bit points away from w.
   function automatic void plru_touch(input int s, input int w);
      int lo, span, node;
      bit up;
      lo = 0; span = NW; node = 0;
      while (span > 1) begin
         up              = (w >= lo + span / 2);
         plru_m[s][node] = !up;
         node            = 2 * node + 1 + int'(up);
         if (up) lo += span / 2;
         span /= 2;
      end
   endfunction

   function automatic int plru_vic(input int s);
      int lo, span, node;
      bit up;
      lo = 0; span = NW; node = 0;
      while (span > 1) begin
         up   = plru_m[s][node];
         node = 2 * node + 1 + int'(up);
         if (up) lo += span / 2;
         span /= 2;
      end
      return lo;
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e = '{default: 0};
      e.hc = hc;
      e.mc = mc;
      return e;
   endfunction

   function automatic exp_t resp_exp(input int w, input bit wr);
      exp_t e;
      e         = idle_exp();
      e.resp    = 1'b1;
      e.chk_way = 1'b1;
      e.way     = w;
      if (wr) begin
         e.ld_data  = 4'b0001 << w;
         e.ld_dirty = 4'b0001 << w;
         e.dsel     = 1'b1;
         e.din      = 1'b1;
      end
      return e;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input int t, input bit rd, input bit wr, input bit presp);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.set_idx   = 3'(s);
      bus.pmem_resp = presp;
      for (int w = 0; w < NW; w++) begin
         bus.hit_vec[w]   = val_m[s][w] && (tag_m[s][w] == t);
         bus.valid_vec[w] = val_m[s][w];
         bus.dirty_vec[w] = dty_m[s][w];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         drive(0, -1, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(idle_exp());
      end
   endtask

   task automatic access(input int s, input int t, input bit wr, input bit rd_too, input int wd,
                         input int fd, output int way, output int lat, output bit hit,
                         output bit wb);
      exp_t e;
      int   hw;
      bit   rd;
      rd = !wr || rd_too;
      hw = -1;
      for (int w = NW - 1; w >= 0; w--) if (val_m[s][w] && tag_m[s][w] == t) hw = w;
      hit = (hw >= 0);
      wb  = 1'b0;
      next_cycle();
      drive(s, t, rd, wr, 1'b0);
      exp_q.push_back(idle_exp());
      next_cycle();
      drive(s, t, rd, wr, 1'b0);
      lat = 2;
      if (hit) begin
         exp_q.push_back(resp_exp(hw, wr));
         plru_touch(s, hw);
         if (wr) dty_m[s][hw] = 1'b1;
         hc  = sat(hc);
         way = hw;
      end else begin
         exp_q.push_back(idle_exp());
         way = -1;
         for (int w = NW - 1; w >= 0; w--) if (!val_m[s][w]) way = w;
         if (way < 0) way = plru_vic(s);
         mc = sat(mc);
         if (dty_m[s][way]) begin
            wb = 1'b1;
            for (int k = 0; k <= wd; k++) begin
               next_cycle();
               drive(s, t, rd, wr, k == wd);
               e = idle_exp();
               e.pwr = 1'b1; e.asel = 1'b1; e.chk_way = 1'b1; e.way = way;
               exp_q.push_back(e);
               lat++;
            end
         end
         for (int k = 0; k <= fd; k++) begin
            next_cycle();
            drive(s, t, rd, wr, k == fd);
            e = idle_exp();
            e.prd = 1'b1;
            if (k == fd) begin
               e.ld_data  = 4'b0001 << way;
               e.ld_tag   = 4'b0001 << way;
               e.ld_valid = 4'b0001 << way;
               e.ld_dirty = 4'b0001 << way;
            end
            exp_q.push_back(e);
            lat++;
         end
         tag_m[s][way] = t;
         val_m[s][way] = 1'b1;
         dty_m[s][way] = 1'b0;
         next_cycle();
         drive(s, t, rd, wr, 1'b0);
         exp_q.push_back(resp_exp(way, wr));
         lat++;
         plru_touch(s, way);
         if (wr) dty_m[s][way] = 1'b1;
      end
   endtask

   // Request withdrawn while the controller is comparing: no response, no side effects.
   task automatic drop_req(input int s);
      next_cycle();
      drive(s, -1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(idle_exp());
      next_cycle();
      drive(s, -1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(idle_exp());
   endtask

   // Miss into an empty set, reset asserted during the second FILL cycle.
   task automatic rst_in_fill(input int s, input int t);
      exp_t e;
      next_cycle();
      drive(s, t, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(idle_exp());
      next_cycle();
      drive(s, t, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(idle_exp());
      mc = sat(mc);
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         drive(s, t, 1'b1, 1'b0, 1'b0);
         if (k == 1) rst = 1'b1;
         e = idle_exp();
         e.prd = 1'b1;
         exp_q.push_back(e);
      end
      next_cycle();
      rst = 1'b0;
      drive(s, t, 1'b0, 1'b0, 1'b0);
      hc = 0;
      mc = 0;
      plru_m = '{default: '{default: 1'b0}};
      exp_q.push_back(idle_exp());
      @(negedge clk);
      chk("rst_pmem_read", int'(bus.pmem_read), 0);
      chk("rst_miss_count", int'(bus.miss_count), 0);
   endtask

   int way, lat;
   bit hit, wb;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      hc       = 0;
      mc       = 0;
      rst      = 1'b1;
      drive(0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         exp_q.push_back(idle_exp());
      end
      next_cycle();
      rst = 1'b0;
      exp_q.push_back(idle_exp());

      // Read miss to empty set 2, memory answers in the 4th FILL cycle
      access(2, 7, 1'b0, 1'b0, 0, 3, way, lat, hit, wb);
      chk("A_victim", way, 0);
      chk("A_writeback", int'(wb), 0);
      chk("A_latency", lat, 7);
      chk("A_hit_count", hc, 0);
      chk("A_miss_count", mc, 1);
      idle(1);

      // Fill set 5 ways 0..3, then PLRU-driven victims
      for (int i = 0; i < 4; i++) begin
         access(5, 10 + i, 1'b0, 1'b0, 0, 1, way, lat, hit, wb);
         chk("B_fill_way", way, i);
      end
      access(5, 14, 1'b0, 1'b0, 0, 0, way, lat, hit, wb);
      chk("B_victim1", way, 0);
      access(5, 15, 1'b0, 1'b0, 0, 2, way, lat, hit, wb);
      chk("B_victim2", way, 2);
      access(5, 11, 1'b0, 1'b0, 0, 0, way, lat, hit, wb);
      chk("B_hit_way1", way, 1);
      access(5, 16, 1'b0, 1'b0, 0, 0, way, lat, hit, wb);
      chk("B_victim3", way, 3);

      // Write hit on way 3, with mem_read also high
      access(5, 16, 1'b1, 1'b1, 0, 0, way, lat, hit, wb);
      chk("C_write_hit", int'(hit), 1);
      chk("C_way", way, 3);
      chk("C_latency", lat, 2);

      // Dirty victim: write-miss makes way 0 of set 1 dirty, then force it out
      access(1, 20, 1'b1, 1'b0, 0, 0, way, lat, hit, wb);
      for (int i = 1; i < 4; i++) access(1, 20 + i, 1'b0, 1'b0, 0, 0, way, lat, hit, wb);
      access(1, 24, 1'b0, 1'b0, 2, 1, way, lat, hit, wb);
      chk("D_writeback", int'(wb), 1);
      chk("D_victim", way, 0);
      chk("D_latency", lat, 8);

      // Reset mid-fill clears counters and PLRU
      rst_in_fill(3, 50);
      access(5, 30, 1'b0, 1'b0, 0, 1, way, lat, hit, wb);
      chk("E_victim_after_rst", way, 0);
      chk("E_miss_count", mc, 1);

      // Counter saturation at 4 bits
      for (int i = 0; i < 20; i++) access(5, 30, 1'b0, 1'b0, 0, 0, way, lat, hit, wb);
      chk("F_model_hit_sat", hc, 15);
      idle(1);
      @(negedge clk);
      chk("F_dut_hit_sat", int'(bus.hit_count), 15);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            drop_req(int'($urandom_range(0, 7)));
         end else begin
            access(int'($urandom_range(0, 7)), 40 + int'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), way, lat, hit, wb);
         end
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(3);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
